// File: rtl/ws2811_rx.sv
// WS2811 single-wire NRZ receiver: measures high-pulse widths on DI, assembles GRB words
// and strobes them out with the LED index of the current frame.
module ws2811_rx #(
   parameter int unsigned NUM_LEDS     = 8,
   parameter int unsigned SYSTEM_CLOCK = 100000000,
   localparam int unsigned AddrW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DI,
   output logic [AddrW-1:0] address,
   output logic [7:0]       red_out,
   output logic [7:0]       green_out,
   output logic [7:0]       blue_out,
   output logic             pixel_valid,
   output logic             frame_done,
   output logic             error
);

   localparam int unsigned BIT_THRESH   = (SYSTEM_CLOCK / 10000000) * 6;
   localparam int unsigned MAX_HIGH     = (SYSTEM_CLOCK / 1000000) * 2;
   localparam int unsigned LATCH_CYCLES = (SYSTEM_CLOCK / 1000000) * 50;
   localparam int unsigned CntW         = $clog2(LATCH_CYCLES + 1);
   localparam int unsigned LedW         = $clog2(NUM_LEDS + 1);

   localparam logic [CntW-1:0] CntOne     = CntW'(1);
   localparam logic [CntW-1:0] ThreshCnt  = CntW'(BIT_THRESH);
   localparam logic [CntW-1:0] MaxHighCnt = CntW'(MAX_HIGH);
   localparam logic [CntW-1:0] LatchCnt   = CntW'(LATCH_CYCLES);
   localparam logic [LedW-1:0] LedMax     = LedW'(NUM_LEDS);

   typedef enum logic [1:0] {StWaitLatch, StIdle, StHigh, StLow} state_e;

   state_e            state_q, state_d;
   logic              sync_q, din_s, din_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [4:0]        bit_idx_q, bit_idx_d;
   logic [LedW-1:0]   led_idx_q, led_idx_d;
   logic [23:0]       shift_q, shift_d;
   logic [AddrW-1:0]  addr_q, addr_d;
   logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic              pv_q, pv_d, fd_q, fd_d, err_q, err_d;
   logic              rise, fall;

   assign rise = din_s & ~din_q;
   assign fall = ~din_s & din_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= 1'b0;
         din_s     <= 1'b0;
         din_q     <= 1'b0;
         state_q   <= StWaitLatch;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         led_idx_q <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
         pv_q      <= 1'b0;
         fd_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync_q    <= DI;
         din_s     <= sync_q;
         din_q     <= din_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         led_idx_q <= led_idx_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         red_q     <= red_d;
         green_q   <= green_d;
         blue_q    <= blue_d;
         pv_q      <= pv_d;
         fd_q      <= fd_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      led_idx_d = led_idx_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      red_d     = red_q;
      green_d   = green_q;
      blue_d    = blue_q;
      pv_d      = 1'b0;
      fd_d      = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         StWaitLatch: begin
            if (din_s) begin
               cnt_d = '0;
            end else if (cnt_q == LatchCnt) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StIdle: begin
            led_idx_d = '0;
            bit_idx_d = '0;
            if (rise) begin
               state_d = StHigh;
               cnt_d   = CntOne;
            end
         end
         StHigh: begin
            if (fall) begin
               shift_d   = {shift_q[22:0], (cnt_q >= ThreshCnt)};
               bit_idx_d = bit_idx_q + 5'd1;
               state_d   = StLow;
               cnt_d     = CntOne;
            end else if (cnt_q == MaxHighCnt) begin
               // Pulse too long to be a bit: drop the word and resynchronise on a latch.
               err_d     = 1'b1;
               bit_idx_d = '0;
               state_d   = StWaitLatch;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StLow: begin
            if (rise) begin
               state_d = StHigh;
               cnt_d   = CntOne;
            end else if (cnt_q == LatchCnt) begin
               fd_d      = 1'b1;
               err_d     = (bit_idx_q != 5'd0);
               bit_idx_d = '0;
               led_idx_d = '0;
               state_d   = StIdle;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: state_d = StWaitLatch;
      endcase

      // Word completion is handled one cycle after the 24th falling edge.
      if (state_q == StLow && bit_idx_q == 5'd24) begin
         bit_idx_d = '0;
         if (led_idx_q != LedMax) led_idx_d = led_idx_q + LedW'(1);
         if (led_idx_q < LedMax) begin
            pv_d    = 1'b1;
            addr_d  = led_idx_q[AddrW-1:0];
            green_d = shift_q[23:16];
            red_d   = shift_q[15:8];
            blue_d  = shift_q[7:0];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   assign address     = addr_q;
   assign red_out     = red_q;
   assign green_out   = green_q;
   assign blue_out    = blue_q;
   assign pixel_valid = pv_q;
   assign frame_done  = fd_q;
   assign error       = err_q;

endmodule
